// File: rtl/rom_boot_sequencer_if.sv
// Image-source stream and SoC ROM loader port, bundled for the boot sequencer.
// master: the sequencer side. slave: the image source plus the SoC loader.
interface rom_boot_sequencer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_last;
  logic                  src_ready;
  logic                  rom_loader_load;
  logic                  rom_loader_sck;
  logic [DATA_WIDTH-1:0] rom_loader_data;
  logic                  rom_loader_ack;

  modport master (
    input  src_valid, src_data, src_last, rom_loader_ack,
    output src_ready, rom_loader_load, rom_loader_sck, rom_loader_data
  );

  modport slave (
    output src_valid, src_data, src_last, rom_loader_ack,
    input  src_ready, rom_loader_load, rom_loader_sck, rom_loader_data
  );
endinterface

// File: rtl/rom_boot_sequencer.sv
// Boot sequencer: copies a word-stream image into the SoC ROM with a 4-phase
// sck/ack handshake, flags timeout / overflow / abort, and holds the CPU in
// reset until the image is in, releasing it RELEASE_DELAY cycles after DONE.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | after reset; auto-starts or waits for start
// S_LOAD_WAIT | session active, src_ready high, waiting for the next word
// S_SETUP     | word on rom_loader_data, holding it SETUP_CYCLES before sck
// S_ACK_HI    | sck high, waiting for ack to rise (timeout armed)
// S_ACK_LO    | sck low, waiting for ack to fall (timeout armed)
// S_DONE      | image loaded; cpu_reset released after the delay
// S_ERROR     | load failed, err_code says why; cpu_reset held
module rom_boot_sequencer #(
  parameter int DATA_WIDTH    = 16,
  parameter int COUNT_WIDTH   = 16,
  parameter int MAX_WORDS     = 32768,
  parameter int ACK_TIMEOUT   = 1024,
  parameter int SETUP_CYCLES  = 2,
  parameter int RELEASE_DELAY = 4,
  parameter int AUTO_START    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  rom_boot_sequencer_if.master   bus,
  input  logic                   i_start,
  input  logic                   i_abort,
  output logic                   o_cpu_reset,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error,
  output logic [1:0]             o_err_code,
  output logic [COUNT_WIDTH-1:0] o_word_count
);

  localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int SU_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int RL_W = (RELEASE_DELAY > 0) ? $clog2(RELEASE_DELAY + 1) : 1;
  localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(MAX_WORDS);
  localparam logic [TO_W-1:0]        TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_WAIT, S_SETUP, S_ACK_HI, S_ACK_LO, S_DONE, S_ERROR
  } state_t;

  state_t                 r_state;
  logic                   r_src_ready;
  logic                   r_load;
  logic                   r_sck;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_last;
  logic                   r_cpu_reset;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;
  logic [1:0]             r_err_code;
  logic [COUNT_WIDTH-1:0] r_word_count;
  logic [SU_W-1:0]        r_setup_cnt;
  logic [TO_W-1:0]        r_to_cnt;
  logic [RL_W-1:0]        r_rel_cnt;

  logic       w_active;
  logic       w_restart;
  logic       w_fail;
  logic [1:0] w_fail_code;

  assign bus.src_ready       = r_src_ready;
  assign bus.rom_loader_load = r_load;
  assign bus.rom_loader_sck  = r_sck;
  assign bus.rom_loader_data = r_data;
  assign o_cpu_reset         = r_cpu_reset;
  assign o_busy              = r_busy;
  assign o_done              = r_done;
  assign o_error             = r_error;
  assign o_err_code          = r_err_code;
  assign o_word_count        = r_word_count;

  // Session (re)start and error detection; abort outranks overflow and timeout,
  // and the restart/fail sets are disjoint so start wins over abort in DONE/ERROR.
  always_comb begin
    w_active    = (r_state == S_LOAD_WAIT) || (r_state == S_SETUP) ||
                  (r_state == S_ACK_HI) || (r_state == S_ACK_LO);
    w_restart   = ((r_state == S_IDLE) && ((AUTO_START != 0) || i_start)) ||
                  (((r_state == S_DONE) || (r_state == S_ERROR)) && i_start);
    w_fail      = 1'b0;
    w_fail_code = 2'd0;
    if (w_active && i_abort) begin
      w_fail      = 1'b1;
      w_fail_code = 2'd3;
    end else if ((r_state == S_LOAD_WAIT) && bus.src_valid && (r_word_count == MAX_CNT)) begin
      w_fail      = 1'b1;
      w_fail_code = 2'd2;
    end else if ((r_to_cnt == TO_LAST) &&
                 (((r_state == S_ACK_HI) && !bus.rom_loader_ack) ||
                  ((r_state == S_ACK_LO) && bus.rom_loader_ack))) begin
      w_fail      = 1'b1;
      w_fail_code = 2'd1;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_src_ready  <= 1'b0;
      r_load       <= 1'b0;
      r_sck        <= 1'b0;
      r_data       <= '0;
      r_last       <= 1'b0;
      r_cpu_reset  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= 2'd0;
      r_word_count <= '0;
      r_setup_cnt  <= '0;
      r_to_cnt     <= '0;
      r_rel_cnt    <= '0;
    end else if (w_restart) begin
      r_state      <= S_LOAD_WAIT;
      r_src_ready  <= 1'b1;
      r_load       <= 1'b1;
      r_sck        <= 1'b0;
      r_cpu_reset  <= 1'b1;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= 2'd0;
      r_word_count <= '0;
    end else if (w_fail) begin
      r_state     <= S_ERROR;
      r_src_ready <= 1'b0;
      r_load      <= 1'b0;
      r_sck       <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_error     <= 1'b1;
      r_err_code  <= w_fail_code;
    end else begin
      case (r_state)
        S_LOAD_WAIT: begin
          if (bus.src_valid) begin
            r_data      <= bus.src_data;
            r_last      <= bus.src_last;
            r_src_ready <= 1'b0;
            r_setup_cnt <= SU_W'(SETUP_CYCLES - 1);
            r_state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_setup_cnt == '0) begin
            r_state  <= S_ACK_HI;
            r_sck    <= 1'b1;
            r_to_cnt <= '0;
          end else begin
            r_setup_cnt <= r_setup_cnt - 1;
          end
        end
        S_ACK_HI: begin
          if (bus.rom_loader_ack) begin
            r_state  <= S_ACK_LO;
            r_sck    <= 1'b0;
            r_to_cnt <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 1;
          end
        end
        S_ACK_LO: begin
          if (!bus.rom_loader_ack) begin
            if (r_word_count != MAX_CNT) r_word_count <= r_word_count + 1;
            if (r_last) begin
              r_state     <= S_DONE;
              r_load      <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_rel_cnt   <= RL_W'(RELEASE_DELAY);
              r_cpu_reset <= (RELEASE_DELAY != 0);
            end else begin
              r_state     <= S_LOAD_WAIT;
              r_src_ready <= 1'b1;
            end
          end else begin
            r_to_cnt <= r_to_cnt + 1;
          end
        end
        S_DONE: begin
          if (r_rel_cnt != '0) begin
            r_rel_cnt <= r_rel_cnt - 1;
            if (r_rel_cnt == RL_W'(1)) r_cpu_reset <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_boot_sequencer.sv
// Directed bench for rom_boot_sequencer. Instance A uses default capacity,
// instance B a 4-word ROM for the overflow case. Both use a 16-cycle ack timeout.
module tb_rom_boot_sequencer;
  localparam int DW = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic a_cpu_reset, a_busy, a_done, a_error, b_cpu_reset, b_busy, b_done, b_error;
  logic [1:0] a_err_code, b_err_code;
  logic [CW-1:0] a_wc, b_wc;

  rom_boot_sequencer_if #(.DATA_WIDTH(DW)) if_a ();
  rom_boot_sequencer_if #(.DATA_WIDTH(DW)) if_b ();

  rom_boot_sequencer #(.ACK_TIMEOUT(16)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a), .i_start(start_a), .i_abort(abort_a),
    .o_cpu_reset(a_cpu_reset), .o_busy(a_busy), .o_done(a_done), .o_error(a_error),
    .o_err_code(a_err_code), .o_word_count(a_wc));

  rom_boot_sequencer #(.MAX_WORDS(4), .ACK_TIMEOUT(16)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b), .i_start(start_b), .i_abort(abort_b),
    .o_cpu_reset(b_cpu_reset), .o_busy(b_busy), .o_done(b_done), .o_error(b_error),
    .o_err_code(b_err_code), .o_word_count(b_wc));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;

  // SoC ack model: 0 = ack follows sck three cycles later, 1 = stuck low,
  // 2 = ack already high when sck rises and drops right after.
  int ack_mode = 0;
  logic [2:0] hist_a = 3'b000, hist_b = 3'b000;
  always @(negedge clk) begin
    hist_a = {hist_a[1:0], if_a.rom_loader_sck};
    hist_b = {hist_b[1:0], if_b.rom_loader_sck};
    case (ack_mode)
      0:       if_a.rom_loader_ack = hist_a[2];
      1:       if_a.rom_loader_ack = 1'b0;
      default: if_a.rom_loader_ack = ~hist_a[1];
    endcase
    if_b.rom_loader_ack = hist_b[2];
  end

  // Observer on instance A, sampled just after each rising edge.
  logic [DW-1:0] cap[$];
  int sck_cyc[$];
  int t_done = -1, t_rel = -1, t_err = -1;
  logic prev_sck = 1'b0, prev_done = 1'b0, prev_cr = 1'b1, prev_err = 1'b0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (if_a.rom_loader_sck && !prev_sck) begin
      cap.push_back(if_a.rom_loader_data);
      sck_cyc.push_back(cyc);
    end
    if (a_done && !prev_done) t_done = cyc;
    if (!a_cpu_reset && prev_cr) t_rel = cyc;
    if (a_error && !prev_err) t_err = cyc;
    prev_sck = if_a.rom_loader_sck; prev_done = a_done;
    prev_cr = a_cpu_reset; prev_err = a_error;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one word (after 'stall' idle cycles) and wait for it to be taken.
  // Called and returns on a falling edge.
  task automatic push(input int sel, input logic [DW-1:0] d, input logic last,
                      input int stall, output bit ok);
    if (stall > 0) begin
      if (sel == 0) if_a.src_valid = 1'b0; else if_b.src_valid = 1'b0;
      repeat (stall) @(negedge clk);
    end
    if (sel == 0) begin
      if_a.src_valid = 1'b1; if_a.src_data = d; if_a.src_last = last;
    end else begin
      if_b.src_valid = 1'b1; if_b.src_data = d; if_b.src_last = last;
    end
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if ((sel == 0) ? if_a.src_ready : if_b.src_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (sel == 0) if_a.src_valid = 1'b0; else if_b.src_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cap.delete(); sck_cyc.delete();
    t_done = -1; t_rel = -1; t_err = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({if_a.src_ready, if_a.rom_loader_load, if_a.rom_loader_sck, if_a.rom_loader_data,
         a_cpu_reset, a_busy, a_done, a_error, a_err_code, a_wc} !==
        {3'b000, 16'h0000, 1'b1, 3'b000, 2'b00, 16'h0000}) begin
      n_err++;
      $display("FAIL reset_values: got rdy=%b load=%b sck=%b data=%h cr=%b busy=%b done=%b err=%b code=%0d wc=%0d",
               if_a.src_ready, if_a.rom_loader_load, if_a.rom_loader_sck, if_a.rom_loader_data,
               a_cpu_reset, a_busy, a_done, a_error, a_err_code, a_wc);
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({if_a.src_ready, if_a.rom_loader_load, a_busy, a_cpu_reset, a_wc} !== {4'b1111, 16'h0000}) begin
      n_err++;
      $display("FAIL auto_start: got rdy=%b load=%b busy=%b cr=%b wc=%0d, want 1 1 1 1 0",
               if_a.src_ready, if_a.rom_loader_load, a_busy, a_cpu_reset, a_wc);
    end
  endtask

  task automatic test_basic_load();
    logic [DW-1:0] w[5] = '{16'h1234, 16'hABCD, 16'h0001, 16'hFFFF, 16'h5A5A};
    bit ok;
    int acc0 = 0;
    pulse_reset();
    ack_mode = 0;
    for (int i = 0; i < 5; i++) begin
      push(0, w[i], (i == 4), 0, ok);
      if (i == 0) acc0 = acc_cyc;
      n_vec++;
      if (ok !== 1'b1) begin n_err++; $display("FAIL basic_accept%0d: got %b want 1", i, ok); end
    end
    for (int t = 0; t < 200; t++) begin if (a_done) break; @(negedge clk); end
    repeat (8) @(negedge clk);
    n_vec++;
    if ({a_done, a_busy, if_a.rom_loader_load, a_cpu_reset, a_wc} !== {4'b1000, 16'd5}) begin
      n_err++;
      $display("FAIL basic_final: got done=%b busy=%b load=%b cr=%b wc=%0d, want 1 0 0 0 5",
               a_done, a_busy, if_a.rom_loader_load, a_cpu_reset, a_wc);
    end
    n_vec++;
    if (cap.size() !== 5) begin n_err++; $display("FAIL basic_sck_count: got %0d want 5", cap.size()); end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (i >= cap.size() || cap[i] !== w[i]) begin
        n_err++;
        $display("FAIL basic_data%0d: got %h want %h", i, (i < cap.size()) ? cap[i] : 16'hxxxx, w[i]);
      end
    end
    // handshake cycle to first sck high: SETUP_CYCLES+1 = 3
    n_vec++;
    if (sck_cyc.size() == 0 || sck_cyc[0] - acc0 !== 3) begin
      n_err++;
      $display("FAIL basic_setup_latency: got %0d want 3", (sck_cyc.size() > 0) ? sck_cyc[0] - acc0 : -1);
    end
    // cpu_reset low RELEASE_DELAY=4 cycles after done rises (5 after last ack fall)
    n_vec++;
    if (t_done < 0 || t_rel - t_done !== 4) begin
      n_err++;
      $display("FAIL basic_release_delay: got %0d want 4", t_rel - t_done);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    pulse_reset();
    ack_mode = 0;
    push(0, 16'h1111, 1'b0, 0, ok);
    push(0, 16'h2222, 1'b0, 0, ok);
    for (int t = 0; t < 100; t++) begin if (a_wc == 2) break; @(negedge clk); end
    ack_mode = 1;
    push(0, 16'h3333, 1'b0, 0, ok);
    for (int t = 0; t < 100; t++) begin if (a_error) break; @(negedge clk); end
    n_vec++;
    if ({a_error, a_err_code, a_wc, if_a.rom_loader_load, a_cpu_reset, if_a.rom_loader_sck, a_busy} !==
        {1'b1, 2'd1, 16'd2, 4'b0100}) begin
      n_err++;
      $display("FAIL timeout_state: got err=%b code=%0d wc=%0d load=%b cr=%b sck=%b busy=%b, want 1 1 2 0 1 0 0",
               a_error, a_err_code, a_wc, if_a.rom_loader_load, a_cpu_reset, if_a.rom_loader_sck, a_busy);
    end
    // ACK_HI entered when sck rose; error 16 cycles later
    n_vec++;
    if (sck_cyc.size() < 3 || t_err - sck_cyc[2] !== 16) begin
      n_err++;
      $display("FAIL timeout_cycles: got %0d want 16", (sck_cyc.size() >= 3) ? t_err - sck_cyc[2] : -1);
    end
    ack_mode = 0;
  endtask

  task automatic test_overflow();
    bit ok;
    pulse_reset();
    for (int i = 0; i < 4; i++) push(1, DW'(16'h0B00 + i), 1'b0, 0, ok);
    push(1, 16'h0B04, 1'b0, 0, ok);
    n_vec++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL ovf_word5_taken: got %b want 1", ok); end
    n_vec++;
    if ({b_error, b_err_code, b_wc, if_b.src_ready, if_b.rom_loader_load} !== {1'b1, 2'd2, 16'd4, 2'b00}) begin
      n_err++;
      $display("FAIL ovf_state: got err=%b code=%0d wc=%0d rdy=%b load=%b, want 1 2 4 0 0",
               b_error, b_err_code, b_wc, if_b.src_ready, if_b.rom_loader_load);
    end
    push(1, 16'h0B05, 1'b0, 0, ok);
    n_vec++;
    if (ok !== 1'b0) begin n_err++; $display("FAIL ovf_word6_refused: got %b want 0", ok); end
  endtask

  task automatic test_abort_restart();
    bit ok;
    pulse_reset();
    ack_mode = 0;
    for (int i = 0; i < 3; i++) push(0, DW'(16'hC000 + i), 1'b0, 0, ok);
    for (int t = 0; t < 100; t++) begin if (if_a.rom_loader_sck && a_wc == 2) break; @(negedge clk); end
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    n_vec++;
    if ({a_error, a_err_code, if_a.rom_loader_sck, if_a.rom_loader_load, a_wc} !== {1'b1, 2'd3, 2'b00, 16'd2}) begin
      n_err++;
      $display("FAIL abort_state: got err=%b code=%0d sck=%b load=%b wc=%0d, want 1 3 0 0 2",
               a_error, a_err_code, if_a.rom_loader_sck, if_a.rom_loader_load, a_wc);
    end
    cap.delete();
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0;
    n_vec++;
    if ({a_busy, a_error, a_err_code, if_a.src_ready, a_wc} !== {1'b1, 1'b0, 2'd0, 1'b1, 16'd0}) begin
      n_err++;
      $display("FAIL start_beats_abort: got busy=%b err=%b code=%0d rdy=%b wc=%0d, want 1 0 0 1 0",
               a_busy, a_error, a_err_code, if_a.src_ready, a_wc);
    end
    push(0, 16'hD00D, 1'b0, 0, ok);
    push(0, 16'hBEEF, 1'b1, 0, ok);
    for (int t = 0; t < 100; t++) begin if (a_done) break; @(negedge clk); end
    n_vec++;
    if ({a_done, a_error, a_wc} !== {2'b10, 16'd2} || cap.size() != 2) begin
      n_err++;
      $display("FAIL abort_reload: got done=%b err=%b wc=%0d pulses=%0d, want 1 0 2 2",
               a_done, a_error, a_wc, cap.size());
    end
    n_vec++;
    if (cap.size() < 2 || cap[0] !== 16'hD00D || cap[1] !== 16'hBEEF) begin
      n_err++;
      $display("FAIL abort_reload_data: got %h %h want d00d beef",
               (cap.size() > 0) ? cap[0] : 16'hxxxx, (cap.size() > 1) ? cap[1] : 16'hxxxx);
    end
  endtask

  task automatic test_reset_midload();
    bit ok;
    pulse_reset();
    ack_mode = 0;
    for (int i = 0; i < 6; i++) push(0, DW'(16'hE000 + i), 1'b0, 0, ok);
    push(0, 16'hE006, 1'b0, 0, ok);
    n_vec++;
    if (a_wc !== 16'd6) begin n_err++; $display("FAIL midload_count: got %0d want 6", a_wc); end
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({if_a.src_ready, if_a.rom_loader_load, if_a.rom_loader_sck, if_a.rom_loader_data,
         a_cpu_reset, a_busy, a_done, a_error, a_err_code, a_wc} !==
        {3'b000, 16'h0000, 1'b1, 3'b000, 2'b00, 16'h0000}) begin
      n_err++;
      $display("FAIL midload_reset: got rdy=%b load=%b sck=%b data=%h cr=%b busy=%b wc=%0d",
               if_a.src_ready, if_a.rom_loader_load, if_a.rom_loader_sck, if_a.rom_loader_data,
               a_cpu_reset, a_busy, a_wc);
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({if_a.rom_loader_load, if_a.src_ready, a_wc} !== {2'b11, 16'd0}) begin
      n_err++;
      $display("FAIL midload_restart: got load=%b rdy=%b wc=%0d want 1 1 0",
               if_a.rom_loader_load, if_a.src_ready, a_wc);
    end
    push(0, 16'hF00D, 1'b1, 0, ok);
    for (int t = 0; t < 100; t++) begin if (a_done) break; @(negedge clk); end
    n_vec++;
    if ({a_done, a_wc} !== {1'b1, 16'd1} || cap.size() != 7) begin
      n_err++;
      $display("FAIL midload_reload: got done=%b wc=%0d pulses=%0d want 1 1 7", a_done, a_wc, cap.size());
    end
  endtask

  task automatic test_back_to_back();
    int stall[6] = '{0, 3, 1, 5, 0, 2};
    logic [DW-1:0] w[6] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};
    bit ok;
    ack_mode = 2;
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      push(0, w[i], (i == 5), stall[i], ok);
      if (i == 1) begin
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n_vec++;
        if (a_busy !== 1'b1) begin n_err++; $display("FAIL start_while_busy: got busy=%b want 1", a_busy); end
      end
    end
    for (int t = 0; t < 200; t++) begin if (a_done) break; @(negedge clk); end
    n_vec++;
    if ({a_done, a_error, a_wc} !== {2'b10, 16'd6} || cap.size() != 6) begin
      n_err++;
      $display("FAIL stall_final: got done=%b err=%b wc=%0d pulses=%0d want 1 0 6 6",
               a_done, a_error, a_wc, cap.size());
    end
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (i >= cap.size() || cap[i] !== w[i]) begin
        n_err++;
        $display("FAIL stall_data%0d: got %h want %h", i, (i < cap.size()) ? cap[i] : 16'hxxxx, w[i]);
      end
    end
    ack_mode = 0;
  endtask

  initial begin
    if_a.src_valid = 1'b0; if_a.src_data = '0; if_a.src_last = 1'b0;
    if_b.src_valid = 1'b0; if_b.src_data = '0; if_b.src_last = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_load();
    test_timeout();
    test_overflow();
    test_abort_restart();
    test_reset_midload();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
